// File: rtl/param_nr_divider.sv
// Parametrised non-restoring sequential divider with start/busy/done handshake.
// Optional signed mode is compiled in when DIV_SIGNED_EN is defined.
module param_nr_divider #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic             dz_pend;

    logic [WIDTH-1:0] x_abs;
    logic [WIDTH-1:0] y_abs;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_step;
    logic [WIDTH:0]   p_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] rem_dz;

`ifdef DIV_SIGNED_EN
    logic [WIDTH-1:0] x_raw;
    logic             neg_q;
    logic             neg_r;
    logic             x_neg;
    logic             y_neg;
`else
    logic             unused_sgn;
    assign unused_sgn = sgn;
`endif

    // Operand magnitudes at load time; MIN maps onto itself, which reads correctly as unsigned.
    always_comb begin
        x_abs = x;
        y_abs = y;
`ifdef DIV_SIGNED_EN
        x_neg = sgn & x[WIDTH-1];
        y_neg = sgn & y[WIDTH-1];
        if (x_neg) x_abs = ~x + 1'b1;
        if (y_neg) y_abs = ~y + 1'b1;
`endif
    end

    // One non-restoring step and the final remainder correction.
    always_comb begin
        p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
        if (p[WIDTH]) p_step = p_shift + {1'b0, d};
        else          p_step = p_shift - {1'b0, d};

        p_fix    = p[WIDTH] ? (p + {1'b0, d}) : p;
        quot_fix = q;
        rem_fix  = p_fix[WIDTH-1:0];
        rem_dz   = q;
`ifdef DIV_SIGNED_EN
        rem_dz = x_raw;
        if (neg_q) quot_fix = ~q + 1'b1;
        if (neg_r) rem_fix  = ~p_fix[WIDTH-1:0] + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            p       <= '0;
            q       <= '0;
            d       <= '0;
            cnt     <= '0;
            dz_pend <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
`ifdef DIV_SIGNED_EN
            x_raw   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p       <= '0;
                        q       <= x_abs;
                        d       <= y_abs;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        dz_pend <= (y == '0);
`ifdef DIV_SIGNED_EN
                        x_raw   <= x;
                        neg_q   <= x_neg ^ y_neg;
                        neg_r   <= x_neg;
`endif
                        state   <= (y == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    p   <= p_step;
                    q   <= {q[WIDTH-2:0], ~p_step[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (dz_pend) begin
                        quot <= '1;
                        rem  <= rem_dz;
                        dz   <= 1'b1;
                    end else begin
                        quot <= quot_fix;
                        rem  <= rem_fix;
                        dz   <= 1'b0;
                    end
                    p       <= p_fix;
                    dz_pend <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/param_nr_divider.md
Name: param_nr_divider

Overview:
- Parametrised non-restoring sequential divider; successor to the fixed 8-bit divider in the ALU datapath.
- Produces quotient and remainder for WIDTH-bit operands, one iteration per enabled clock.
- Adds a start/busy/done handshake, remainder correction, divide-by-zero detection and an optional signed mode.
- Sits behind the ALU opcode decoder; the ALU holds operands stable only for the start cycle.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (legal 4..32).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- res  in  1  synchronous, active-high reset.
- en  in  1  clock enable; 0 freezes all state, outputs hold.
- start  in  1  request; sampled only in IDLE with en=1.
- sgn  in  1  1 = signed division (only with DIV_SIGNED_EN); latched at start.
- x  in  WIDTH  dividend; latched at start.
- y  in  WIDTH  divisor; latched at start.
- quot  out  WIDTH  quotient; valid while done=1 and held until the next start.
- rem  out  WIDTH  remainder; same validity as quot.
- busy  out  1  high from the start-accept edge until the result edge.
- done  out  1  one-cycle pulse (in en-cycles) when quot/rem become valid.
- dz  out  1  divide-by-zero flag; updated with done, held until the next start.

Behaviour:
- Reset (res=1 at posedge, overrides en): state=IDLE, quot=0, rem=0, busy=0, done=0, dz=0, counter=0, internal accumulator=0. Reset mid-operation aborts the division; no done is produced.
- States: IDLE, ITER, FIX.
- IDLE, start=1, en=1:
  - Latch operands. In signed mode, latch absolute values and record the result signs.
  - Partial remainder P (WIDTH+1 bits) = 0; quotient register = |x|; counter=0; busy=1.
  - If y==0, go to FIX with dz pending. Otherwise go to ITER.
- ITER, one step per en cycle:
  - Shift {P,Q} left by 1.
  - If P >= 0, P = P - D; else P = P + D.
  - Q[0] = ~P[WIDTH].
  - Counter increments; after the WIDTH-th step, go to FIX.
- FIX:
  - If P < 0, P = P + D.
  - Signed mode: negate quot if the operand signs differ; remainder takes the dividend's sign.
  - Drive quot and rem, pulse done=1, set busy=0, return to IDLE.
- Divide-by-zero: quot = all ones, rem = x (raw latched dividend), dz=1. Latency is 2 edges.
- Latency (y != 0): start accepted at edge k; done=1 and results valid after edge k+WIDTH+1. The next start is accepted at the earliest on the edge where done=1 is visible, i.e. back-to-back operation is allowed.
- start while busy=1 is ignored and has no side effects.
- done deasserts on the next en=1 edge. With en=0 it stays high until that edge.
- Signed overflow (MIN / -1): quot = MIN (two's-complement wrap), rem=0, dz=0.
- Rounding: quotient truncates toward zero; |rem| < |y|.
- Arithmetic is internally WIDTH+1 bits, so there is no overflow in the partial remainder.

Optional Feature:
- DIV_SIGNED_EN defined: sgn port is honoured; sign handling in load and FIX is compiled in.
- DIV_SIGNED_EN undefined: sgn is ignored and must still exist on the port list. The divider is unsigned only and the sign logic is removed.

Test Plan:
- WIDTH=8, unsigned, x=100, y=7, start at edge k -> done after edge k+9, quot=14, rem=2, dz=0; busy high for 9 cycles.
- x=255, y=1 -> quot=255, rem=0; then x=5, y=0 -> done after 2 edges, quot=0xFF, rem=5, dz=1; the next valid division clears dz.
- DIV_SIGNED_EN, sgn=1, x=0xF9 (-7), y=2 -> quot=0xFD (-3), rem=0xFF (-1); x=0x80, y=0xFF -> quot=0x80, rem=0.
- en low for 3 cycles mid-ITER with x=200, y=9 -> done is delayed by exactly 3 cycles; result quot=22, rem=2.
- start pulsed again while busy with different operands -> ignored; first result (quot=14, rem=2) is unchanged.
- res asserted at the 4th ITER cycle -> all outputs 0 the next cycle, no done pulse; a subsequent start runs normally.
